// File: rtl/output_byte_counter.sv
// Pass-through stage that tallies IO-queue header byte lengths into four per-MAC-queue counters.
// Optional OUTPUT_BYTE_COUNTER_CLEAR_EN adds a synchronous counters_clear input.
module output_byte_counter #(
    parameter int                     DATA_WIDTH    = 64,
    parameter int                     CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0]  IOQ_STAGE_NUM = 8'hFF,
    parameter int                     DST_PORT_POS  = 48,
    parameter int                     BYTE_LEN_POS  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
`ifdef OUTPUT_BYTE_COUNTER_CLEAR_EN
    input  logic                  counters_clear,
`endif
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           q0_num_bytes_pushed,
    output logic [31:0]           q1_num_bytes_pushed,
    output logic [31:0]           q2_num_bytes_pushed,
    output logic [31:0]           q3_num_bytes_pushed
);

    localparam int MAX_DEPTH_BITS = 2;
    localparam int MAX_DEPTH      = 1 << MAX_DEPTH_BITS;
    localparam int FIFO_WIDTH     = DATA_WIDTH + CTRL_WIDTH;

    localparam logic [0:0] WAIT_HDR = 1'b0;
    localparam logic [0:0] IN_PKT   = 1'b1;

    logic [FIFO_WIDTH-1:0]     mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      nearly_full;
    logic                      empty;
    logic                      wr_en;
    logic                      rd_en;

    logic [FIFO_WIDTH-1:0]     head;
    logic [CTRL_WIDTH-1:0]     head_ctrl;
    logic [DATA_WIDTH-1:0]     head_data;
    logic [15:0]               dst_ports;
    logic [15:0]               byte_len;
    logic                      hdr_pop;
    logic                      clear_req;

    logic [0:0]                state;
    logic [0:0]                state_next;
    logic [31:0]               q_cnt  [4];
    logic [31:0]               q_next [4];

`ifdef OUTPUT_BYTE_COUNTER_CLEAR_EN
    assign clear_req = counters_clear;
`else
    assign clear_req = 1'b0;
`endif

    assign full        = (depth == (MAX_DEPTH_BITS+1)'(MAX_DEPTH));
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(MAX_DEPTH - 1));
    assign empty       = (depth == '0);
    assign in_rdy      = !nearly_full;
    assign wr_en       = in_wr && !full;
    assign rd_en       = !empty && out_rdy;

    // Fallthrough read: the head entry is visible combinationally.
    assign head      = mem[rd_ptr];
    assign head_ctrl = head[FIFO_WIDTH-1:DATA_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];
    assign dst_ports = head_data[DST_PORT_POS +: 16];
    assign byte_len  = head_data[BYTE_LEN_POS +: 16];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_ctrl, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            out_wr <= rd_en;
            if (rd_en) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

    assign hdr_pop = rd_en && (state == WAIT_HDR) && (head_ctrl == IOQ_STAGE_NUM);

    always_comb begin
        state_next = state;
        if (rd_en) begin
            if (state == WAIT_HDR) begin
                if (head_ctrl == '0) state_next = IN_PKT;
            end else if (head_ctrl != '0) begin
                state_next = WAIT_HDR;
            end
        end
    end

    // Clear takes priority over the held value but not over a coincident header.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            q_next[i] = clear_req ? '0 : q_cnt[i];
            if (hdr_pop && dst_ports[2*i])
                q_next[i] = q_next[i] + {16'h0000, byte_len};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_HDR;
            for (int unsigned i = 0; i < 4; i++) q_cnt[i] <= '0;
        end else begin
            state <= state_next;
            for (int unsigned i = 0; i < 4; i++) q_cnt[i] <= q_next[i];
        end
    end

    assign q0_num_bytes_pushed = q_cnt[0];
    assign q1_num_bytes_pushed = q_cnt[1];
    assign q2_num_bytes_pushed = q_cnt[2];
    assign q3_num_bytes_pushed = q_cnt[3];

endmodule

// File: tb/tb_output_byte_counter.sv
// Directed self-checking bench for output_byte_counter (clear port exercised when
// OUTPUT_BYTE_COUNTER_CLEAR_EN is defined).
module tb_output_byte_counter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic [31:0] q0, q1, q2, q3;
`ifdef OUTPUT_BYTE_COUNTER_CLEAR_EN
    logic        counters_clear = 1'b0;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          rec   = 1'b1;
    logic [71:0] exp_q[$];
    logic [71:0] out_q[$];

    output_byte_counter dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_data             (in_data),
        .in_ctrl             (in_ctrl),
        .in_wr               (in_wr),
        .in_rdy              (in_rdy),
`ifdef OUTPUT_BYTE_COUNTER_CLEAR_EN
        .counters_clear      (counters_clear),
`endif
        .out_data            (out_data),
        .out_ctrl            (out_ctrl),
        .out_wr              (out_wr),
        .out_rdy             (out_rdy),
        .q0_num_bytes_pushed (q0),
        .q1_num_bytes_pushed (q1),
        .q2_num_bytes_pushed (q2),
        .q3_num_bytes_pushed (q3)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rec && out_wr) out_q.push_back({out_ctrl, out_data});
        end
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [15:0] dst, input logic [15:0] len);
        return {dst, 32'h0000_0000, len};
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        int unsigned n = 0;
        while (!in_rdy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_rdy) begin
            check("in_rdy_wait", 72'(in_rdy), 72'd1);
            return;
        end
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        if (rec) exp_q.push_back({c, d});
        @(posedge clk);
        #1;
        in_wr = 1'b0;
    endtask

    task automatic send_data(input int unsigned ndata, input logic [15:0] tag);
        for (int unsigned i = 0; i < ndata; i++)
            send_word((i == ndata - 1) ? 8'h80 : 8'h00, {16'hDA7A, 16'(i), tag, 16'h5A5A});
    endtask

    task automatic send_pkt(input logic [15:0] dst, input logic [15:0] len, input int unsigned ndata);
        send_word(8'hFF, hdr(dst, len));
        send_data(ndata, len);
    endtask

    task automatic check_q(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        check({tag, "_q0"}, 72'(q0), 72'(e0));
        check({tag, "_q1"}, 72'(q1), 72'(e1));
        check({tag, "_q2"}, 72'(q2), 72'(e2));
        check({tag, "_q3"}, 72'(q3), 72'(e3));
    endtask

    task automatic compare_stream(input string tag);
        int unsigned n;
        check({tag, "_nwords"}, 72'(out_q.size()), 72'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++)
            check({tag, "_word"}, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        #3;
        check("rst_out_wr", 72'(out_wr), 72'd0);
        check("rst_out_data", 72'(out_data), 72'd0);
        check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
        check("rst_in_rdy", 72'(in_rdy), 72'd1);
        check_q("rst", 0, 0, 0, 0);
        idle(2);
        reset_n = 1'b1;
        idle(1);

        // Single packet with 1-cycle latency
        send_word(8'hFF, hdr(16'h0001, 16'd60));
        check("lat_pre_out_wr", 72'(out_wr), 72'd0);
        check("lat_pre_q0", 72'(q0), 72'd0);
        send_word(8'h00, {16'hDA7A, 16'd0, 16'd60, 16'h5A5A});
        check("lat_out_wr", 72'(out_wr), 72'd1);
        check("lat_word", {out_ctrl, out_data}, {8'hFF, hdr(16'h0001, 16'd60)});
        check("lat_q0", 72'(q0), 72'd60);
        for (int unsigned i = 1; i < 7; i++)
            send_word((i == 6) ? 8'h80 : 8'h00, {16'hDA7A, 16'(i), 16'd60, 16'h5A5A});
        idle(4);
        check_q("single", 60, 0, 0, 0);
        compare_stream("single");

        // Multicast, CPU-only, zero length, no destination
        send_pkt(16'h0055, 16'd1500, 3);
        idle(3);
        check_q("mcast", 1560, 1500, 1500, 1500);
        send_pkt(16'h00AA, 16'd1500, 3);
        send_pkt(16'h000F, 16'd0, 2);
        send_pkt(16'h0000, 16'd5, 2);
        idle(3);
        check_q("nochg", 1560, 1500, 1500, 1500);

        // IOQ-valued ctrl inside a packet ends it and is not counted
        send_word(8'hFF, hdr(16'h0004, 16'd10));
        send_word(8'h00, 64'h1111_2222_3333_4444);
        send_word(8'hFF, hdr(16'h0001, 16'd999));
        send_pkt(16'h0001, 16'd40, 2);
        idle(3);
        check_q("inpkt_ioq", 1600, 1510, 1500, 1500);
        compare_stream("misc");

        // Wrap of q2
        do_reset();
        rec = 1'b0;
        for (int unsigned i = 0; i < 65536; i++) send_word(8'hFF, hdr(16'h0010, 16'hFFFF));
        send_word(8'hFF, hdr(16'h0010, 16'hFFF0));
        idle(3);
        check_q("prewrap", 0, 0, 32'hFFFF_FFF0, 0);
        send_word(8'hFF, hdr(16'h0010, 16'h0020));
        idle(3);
        check_q("wrap", 0, 0, 32'h0000_0010, 0);
        rec = 1'b1;

        // Backpressure
        do_reset();
        out_rdy = 1'b0;
        fork
            send_pkt(16'h0001, 16'd60, 7);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_rdy", 72'(in_rdy), 72'd0);
                check("bp_out_wr", 72'(out_wr), 72'd0);
                check("bp_q0", 72'(q0), 72'd0);
                repeat (5) @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        idle(6);
        check_q("bp", 60, 0, 0, 0);
        compare_stream("bp");

        // Async reset mid-packet
        do_reset();
        send_pkt(16'h0004, 16'd300, 3);
        idle(3);
        check("mid_q1", 72'(q1), 72'd300);
        send_word(8'hFF, hdr(16'h0001, 16'd99));
        send_word(8'h00, 64'hAAAA_0000_0000_0001);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_wr", 72'(out_wr), 72'd0);
        check("mid_rst_out_data", 72'(out_data), 72'd0);
        check("mid_rst_in_rdy", 72'(in_rdy), 72'd1);
        check_q("mid_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        out_q.delete();
        exp_q.delete();
        send_data(3, 16'hBEEF);
        send_pkt(16'h0004, 16'd64, 2);
        idle(3);
        check_q("post_rst", 0, 64, 0, 0);
        compare_stream("post_rst");

`ifdef OUTPUT_BYTE_COUNTER_CLEAR_EN
        send_pkt(16'h0001, 16'd50, 2);
        idle(3);
        send_word(8'hFF, hdr(16'h0004, 16'd100));
        counters_clear = 1'b1;
        send_word(8'h00, 64'h0);
        counters_clear = 1'b0;
        send_word(8'h80, 64'h1);
        idle(3);
        check_q("clr_hdr", 0, 100, 0, 0);
        counters_clear = 1'b1;
        idle(1);
        counters_clear = 1'b0;
        check_q("clr_idle", 0, 0, 0, 0);
        compare_stream("clr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
